branch_predictor_gshare: RTL and testbench
==========================================

Name: branch_predictor_gshare

Overview:
Parametrised dual-lane branch direction predictor: pattern history table (PHT) of saturating counters, indexed by PC alone (bimodal mode) or PC XOR global history (gshare mode). Sits between fetch and execute in the superscalar core. Provides two same-cycle lane predictions plus one fetch-lookahead prediction. Takes two resolved-branch updates per cycle from execute. Maintains a speculative global history register (GHR) with restore on mispredict, and self-initialises the PHT after reset through an init sweep.

Parameters:
PC_W, 11, PC width in bits
IDX_W, 5, PHT index width; PHT depth = 2^IDX_W
CTR_W, 2, counter width in bits (>=2)
GHR_W, 5, global history length (1..IDX_W)
USE_GHR, 1, 1 = gshare index, 0 = bimodal index (GHR still tracked)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pc1  in  PC_W  lane-1 fetch PC
pc2  in  PC_W  lane-2 fetch PC
fetch_br1  in  1  lane-1 holds a branch entering pipeline this cycle (push GHR)
fetch_br2  in  1  lane-2 holds a branch entering pipeline this cycle (push GHR)
nextPC  in  PC_W  lookahead PC for instruction-memory prediction
prediction1  out  1  lane-1 taken prediction
prediction2  out  1  lane-2 taken prediction
instMemPred  out  1  lookahead taken prediction
ghr_snap1  out  GHR_W  GHR used to index lane 1 (carried down pipe)
ghr_snap2  out  GHR_W  GHR used to index lane 2
branch1  in  1  lane-1 execute-stage branch resolves this cycle
branch2  in  1  lane-2 execute-stage branch resolves this cycle
pcE1  in  PC_W  lane-1 execute PC
pcE2  in  PC_W  lane-2 execute PC
branch_taken1  in  1  lane-1 actual outcome
branch_taken2  in  1  lane-2 actual outcome
ghrE1  in  GHR_W  snapshot returned with lane-1 branch
ghrE2  in  GHR_W  snapshot returned with lane-2 branch
mispredict1  in  1  lane-1 prediction was wrong
mispredict2  in  1  lane-2 prediction was wrong
ready  out  1  PHT initialised; predictions valid

Behaviour:
- Single clock domain. Every state element resets synchronously when reset=1 on a rising edge of clk.
- Reset values: GHR=0, FSM=INIT, init pointer=0, ready=0. prediction1/2 and instMemPred are 0 whenever ready=0.
- FSM INIT: one PHT entry per cycle is written with WNT = 2^(CTR_W-1)-1 (01 for CTR_W=2), at pointer 0..2^IDX_W-1.
  - The pointer wraps at the last entry; FSM then moves to RUN, and ready=1 from the following cycle.
  - Init takes exactly 2^IDX_W cycles after reset deasserts.
  - Updates and GHR pushes are ignored in INIT.
- FSM RUN: stays in RUN until reset. Reset asserted mid-RUN or mid-INIT restarts INIT from pointer 0.
- Index function: idx(pc,h) = pc[IDX_W-1:0] XOR zero-extend(h) if USE_GHR=1, else pc[IDX_W-1:0].
- Predictions are combinational, same cycle, reading the pre-update PHT. Taken = counter MSB.
  - lane 1: idx(pc1, GHR); ghr_snap1 = GHR.
  - lane 2: h2 = fetch_br1 ? {GHR[GHR_W-2:0], prediction1} : GHR; idx(pc2, h2); ghr_snap2 = h2.
  - lookahead: idx(nextPC, GHR).
- Speculative GHR push at clock edge: shift in prediction1 if fetch_br1, then prediction2 if fetch_br2 (two pushes are allowed in one cycle).
- Mispredict restore overrides the push:
  - lane 1 (older) priority: if branch1 & mispredict1, GHR <= {ghrE1[GHR_W-2:0], branch_taken1}.
  - else if branch2 & mispredict2, GHR <= {ghrE2[GHR_W-2:0], branch_taken2}.
- PHT update when branchN=1: entry idx(pcEN, ghrEN) increments (taken) or decrements (not taken), saturating at 0 and 2^CTR_W-1. Result is visible to predictions on the next cycle.
- Both lanes hitting the same index: apply lane 1 then lane 2 to the same cycle's value (net two steps, still saturating). Example: 01 with taken, taken becomes 11.
- Mispredict on lane 1 does not suppress lane-2's PHT update in the same cycle; squash is the pipeline's job.

Test Plan:
- reset=1 for 2 cycles then 0 -> ready=0 and all predictions 0 for 32 cycles; ready=1 on cycle 33; every entry reads 01 (prediction 0).
- USE_GHR=0: branch1=1, pcE1=0x005, taken three times -> counter 01->10->11->11; prediction1 for pc1=0x005 is 1 after the first update, and 0x025 aliases to the same entry.
- USE_GHR=1, GHR=0: fetch_br1=fetch_br2=1 with predictions 1,0 -> GHR becomes 00010; ghr_snap2 = 00001.
- Same cycle fetch pushes and branch1 & mispredict1 with ghrE1=10110, taken=1 -> GHR=01101 (restore wins); simultaneous lane-2 mispredict ignored.
- Both update lanes same index 7, counter 01, taken/taken -> 11. Not-taken/not-taken from 00 -> stays 00.
- Reset asserted in RUN after training entry 3 to 11 -> ready drops next cycle; after 32-cycle init, entry 3 reads 01 and GHR = 0.

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - dual-lane gshare/bimodal branch direction predictor
//
// Purpose: a pattern history table (PHT) of saturating counters gives two same-cycle
// lane predictions and one fetch-lookahead prediction. It takes two resolved-branch
// updates per cycle, keeps a speculative global history register (GHR) that is
// restored on mispredict, and fills the PHT with weakly-not-taken after reset.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   pc1, pc2, nextPC               lane-1 / lane-2 fetch PCs, lookahead PC
//   fetch_br1, fetch_br2           fetch lane holds a branch (speculative GHR push)
//   prediction1/2, instMemPred     taken predictions (0 while not ready)
//   ghr_snap1, ghr_snap2           history used to index each lane
//   branch1/2, pcE1/2              execute-stage resolution and its PC
//   branch_taken1/2, ghrE1/2       actual outcome and returned history snapshot
//   mispredict1/2                  lane prediction was wrong
//   ready                          PHT initialised, predictions valid
module branch_predictor_gshare #(
    parameter int PC_W    = 11,
    parameter int IDX_W   = 5,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 5,
    parameter bit USE_GHR = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc1,
    input  logic [PC_W-1:0]  pc2,
    input  logic             fetch_br1,
    input  logic             fetch_br2,
    input  logic [PC_W-1:0]  nextPC,
    output logic             prediction1,
    output logic             prediction2,
    output logic             instMemPred,
    output logic [GHR_W-1:0] ghr_snap1,
    output logic [GHR_W-1:0] ghr_snap2,
    input  logic             branch1,
    input  logic             branch2,
    input  logic [PC_W-1:0]  pcE1,
    input  logic [PC_W-1:0]  pcE2,
    input  logic             branch_taken1,
    input  logic             branch_taken2,
    input  logic [GHR_W-1:0] ghrE1,
    input  logic [GHR_W-1:0] ghrE2,
    input  logic             mispredict1,
    input  logic             mispredict2,
    output logic             ready
);

    localparam int              DEPTH   = 1 << IDX_W;
    localparam logic [CTR_W-1:0] WNT    = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic             init_we;
    logic [IDX_W-1:0] init_ptr;
    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] ghr_next;
    logic [GHR_W-1:0] h2;
    logic [CTR_W-1:0] pht [DEPTH];

    logic [IDX_W-1:0] idx1, idx2, idx_la;
    logic [IDX_W-1:0] upd_idx1, upd_idx2;
    logic [CTR_W-1:0] upd_val1, upd_val2, upd_base2;

    // PC bits above the index never reach the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc1[PC_W-1:IDX_W], pc2[PC_W-1:IDX_W], nextPC[PC_W-1:IDX_W],
                              pcE1[PC_W-1:IDX_W], pcE2[PC_W-1:IDX_W]};

    // Shift one outcome into a history value; the oldest bit falls off the top.
    function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] h, input logic b);
        logic [GHR_W-1:0] r;
        r    = h << 1;
        r[0] = b;
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc,
                                                 input logic [GHR_W-1:0] h);
        if (USE_GHR)
            return pc[IDX_W-1:0] ^ IDX_W'(h);
        else
            return pc[IDX_W-1:0];
    endfunction

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c, input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + CTR_W'(1);
        else
            return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_ptr == IDX_W'(DEPTH - 1))
            state_next = ST_RUN;
    end

    // FSM: outputs
    always_comb begin
        ready   = (state == ST_RUN);
        init_we = (state == ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (reset)
            init_ptr <= '0;
        else if (init_we)
            init_ptr <= init_ptr + IDX_W'(1);
    end

    // Lane 2 sees lane 1's prediction already shifted in when lane 1 is a branch.
    assign h2     = fetch_br1 ? shift_in(ghr, prediction1) : ghr;
    assign idx1   = idx_of(pc1, ghr);
    assign idx2   = idx_of(pc2, h2);
    assign idx_la = idx_of(nextPC, ghr);

    assign prediction1 = ready & pht[idx1][CTR_W-1];
    assign prediction2 = ready & pht[idx2][CTR_W-1];
    assign instMemPred = ready & pht[idx_la][CTR_W-1];
    assign ghr_snap1   = ghr;
    assign ghr_snap2   = h2;

    // Counter updates; a same-index lane 2 builds on lane 1's result so both steps land.
    always_comb begin
        upd_idx1  = idx_of(pcE1, ghrE1);
        upd_idx2  = idx_of(pcE2, ghrE2);
        upd_val1  = sat_step(pht[upd_idx1], branch_taken1);
        upd_base2 = (branch1 && upd_idx1 == upd_idx2) ? upd_val1 : pht[upd_idx2];
        upd_val2  = sat_step(upd_base2, branch_taken2);
    end

    // Speculative pushes, overridden by a mispredict restore (older lane first).
    always_comb begin
        ghr_next = ghr;
        if (fetch_br1)
            ghr_next = shift_in(ghr_next, prediction1);
        if (fetch_br2)
            ghr_next = shift_in(ghr_next, prediction2);
        if (branch1 && mispredict1)
            ghr_next = shift_in(ghrE1, branch_taken1);
        else if (branch2 && mispredict2)
            ghr_next = shift_in(ghrE2, branch_taken2);
    end

    always_ff @(posedge clk) begin
        if (reset)
            ghr <= '0;
        else if (state == ST_RUN)
            ghr <= ghr_next;
    end

    // Table contents are rebuilt by the init sweep instead of a reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we) begin
                pht[init_ptr] <= WNT;
            end else begin
                if (branch1)
                    pht[upd_idx1] <= upd_val1;
                if (branch2)
                    pht[upd_idx2] <= upd_val2;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - self-checking bench for branch_predictor_gshare
module tb_branch_predictor_gshare;

    logic       clk = 1'b0;
    logic       reset;
    logic [10:0] pc1, pc2, nextPC, pcE1, pcE2;
    logic       fetch_br1, fetch_br2, branch1, branch2;
    logic       branch_taken1, branch_taken2, mispredict1, mispredict2;
    logic [4:0] ghrE1, ghrE2;

    logic       pred1_g, pred2_g, imp_g, ready_g;
    logic [4:0] snap1_g, snap2_g;
    logic       pred1_b, pred2_b, imp_b, ready_b;
    logic [4:0] snap1_b, snap2_b;

    always #5 clk = ~clk;

    branch_predictor_gshare #(.USE_GHR(1'b1)) dut_g (
        .clk(clk), .reset(reset), .pc1(pc1), .pc2(pc2),
        .fetch_br1(fetch_br1), .fetch_br2(fetch_br2), .nextPC(nextPC),
        .prediction1(pred1_g), .prediction2(pred2_g), .instMemPred(imp_g),
        .ghr_snap1(snap1_g), .ghr_snap2(snap2_g),
        .branch1(branch1), .branch2(branch2), .pcE1(pcE1), .pcE2(pcE2),
        .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
        .ghrE1(ghrE1), .ghrE2(ghrE2),
        .mispredict1(mispredict1), .mispredict2(mispredict2), .ready(ready_g)
    );

    branch_predictor_gshare #(.USE_GHR(1'b0)) dut_b (
        .clk(clk), .reset(reset), .pc1(pc1), .pc2(pc2),
        .fetch_br1(fetch_br1), .fetch_br2(fetch_br2), .nextPC(nextPC),
        .prediction1(pred1_b), .prediction2(pred2_b), .instMemPred(imp_b),
        .ghr_snap1(snap1_b), .ghr_snap2(snap2_b),
        .branch1(branch1), .branch2(branch2), .pcE1(pcE1), .pcE2(pcE2),
        .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
        .ghrE1(ghrE1), .ghrE2(ghrE2),
        .mispredict1(mispredict1), .mispredict2(mispredict2), .ready(ready_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd1(input logic [10:0] pc, input logic taken, input logic [4:0] h);
        branch1 = 1'b1; pcE1 = pc; branch_taken1 = taken; ghrE1 = h;
        tick();
        branch1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pc1 = '0; pc2 = '0; nextPC = '0; pcE1 = '0; pcE2 = '0;
        fetch_br1 = 0; fetch_br2 = 0; branch1 = 0; branch2 = 0;
        branch_taken1 = 0; branch_taken2 = 0; mispredict1 = 0; mispredict2 = 0;
        ghrE1 = '0; ghrE2 = '0;
        tick();
        tick();
        reset = 1'b0;

        // Init sweep: not ready, predictions forced low for 32 cycles.
        for (int i = 0; i < 32; i++) begin
            expect_val($sformatf("init_wait_%0d", i), 32'h0);
            #1;
            check({ready_g, ready_b, pred1_g, pred2_g, imp_g, pred1_b});
            tick();
        end
        expect_val("ready_after_init", 32'h3);
        #1;
        check({ready_g, ready_b});

        // Every entry weakly not taken.
        for (int i = 0; i < 32; i++) begin
            pc1 = 11'(i); pc2 = 11'(i); nextPC = 11'(i);
            expect_val($sformatf("entry_wnt_%0d", i), 32'h0);
            #1;
            check({pred1_g, pred2_g, imp_g, pred1_b, pred2_b, imp_b});
        end

        // Bimodal training on 0x005, alias 0x025, saturation at 11.
        upd1(11'h005, 1'b1, 5'b0);
        pc1 = 11'h005; pc2 = 11'h025;
        expect_val("bimodal_first_taken_and_alias", 32'h3);
        #1;
        check({pred1_b, pred2_b});
        upd1(11'h005, 1'b1, 5'b0);
        upd1(11'h005, 1'b1, 5'b0);
        upd1(11'h005, 1'b0, 5'b0);
        expect_val("bimodal_saturated_then_nt", 32'h1);
        #1;
        check({31'b0, pred1_b});
        upd1(11'h005, 1'b0, 5'b0);
        expect_val("bimodal_back_to_wnt", 32'h0);
        #1;
        check({31'b0, pred1_b});

        // Dual speculative push with predictions 1,0.
        upd1(11'h009, 1'b1, 5'b0);
        pc1 = 11'h009; pc2 = 11'h000; fetch_br1 = 1; fetch_br2 = 1;
        expect_val("push_snaps_preds", {20'b0, 5'b00000, 5'b00001, 2'b10});
        #1;
        check({20'b0, snap1_g, snap2_g, pred1_g, pred2_g});
        tick();
        fetch_br1 = 0; fetch_br2 = 0;
        expect_val("ghr_after_two_pushes", 32'b00010);
        #1;
        check({27'b0, snap1_g});

        // Lane-1 restore beats pushes and lane-2 mispredict.
        fetch_br1 = 1; fetch_br2 = 1;
        branch1 = 1; mispredict1 = 1; ghrE1 = 5'b10110; branch_taken1 = 1; pcE1 = 11'h016;
        branch2 = 1; mispredict2 = 1; ghrE2 = 5'b11111; branch_taken2 = 0; pcE2 = 11'h01E;
        tick();
        fetch_br1 = 0; fetch_br2 = 0; branch1 = 0; branch2 = 0;
        mispredict1 = 0; mispredict2 = 0;
        expect_val("restore_lane1_wins", {22'b0, 5'b01101, 5'b01101});
        #1;
        check({22'b0, snap1_g, snap1_b});

        // Both lanes taken on index 7: 01 -> 11.
        branch1 = 1; branch2 = 1; pcE1 = 11'h007; pcE2 = 11'h007;
        ghrE1 = '0; ghrE2 = '0; branch_taken1 = 1; branch_taken2 = 1;
        tick();
        branch1 = 0; branch2 = 0;
        pc1 = 11'h007; nextPC = 11'h00A;
        expect_val("dual_taken_idx7", 32'h3);
        #1;
        check({pred1_b, imp_g});
        upd1(11'h007, 1'b0, 5'b0);
        expect_val("dual_taken_idx7_was_11", 32'h3);
        #1;
        check({pred1_b, imp_g});

        // Both lanes not taken from 00 on index 8 stays 00.
        upd1(11'h008, 1'b0, 5'b0);
        branch1 = 1; branch2 = 1; pcE1 = 11'h008; pcE2 = 11'h008;
        branch_taken1 = 0; branch_taken2 = 0;
        tick();
        branch1 = 0; branch2 = 0;
        pc1 = 11'h008; nextPC = 11'h005;
        expect_val("dual_nt_idx8", 32'h0);
        #1;
        check({pred1_b, imp_g});
        upd1(11'h008, 1'b1, 5'b0);
        expect_val("dual_nt_idx8_floor", 32'h0);
        #1;
        check({pred1_b, imp_g});

        // Reset from RUN after training entry 3 to strongly taken.
        upd1(11'h003, 1'b1, 5'b0);
        upd1(11'h003, 1'b1, 5'b0);
        pc1 = 11'h003; nextPC = 11'h00E;
        expect_val("entry3_trained", 32'h3);
        #1;
        check({pred1_b, imp_g});
        reset = 1'b1;
        tick();
        expect_val("ready_drops_on_reset", 32'h0);
        #1;
        check({ready_g, ready_b});
        reset = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        expect_val("reinit_not_ready_yet", 32'h0);
        #1;
        check({ready_g, ready_b});
        tick();
        expect_val("reinit_entry3_ghr", {25'b0, 1'b1, 5'b00000, 1'b0});
        #1;
        check({25'b0, ready_g, snap1_g, pred1_g});
        expect_val("reinit_entry3_bimodal", 32'h2);
        check({ready_b, pred1_b});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
